// File: rtl/boothmul_arbiter.sv
// boothmul_arbiter: round-robin sharing of one external boothmul among N_REQ requesters.
//   clk, rst_n            clock, asynchronous active-low reset
//   req, a1_in, a2_in     per-requester request level and packed operands
//   grant, done           one-hot owner, one-cycle completion pulse to the owner
//   result, err, busy     captured product, timeout flag, BUSY/DONE indicator
//   mul_arm, mul_a1/a2    drive the boothmul from latched operands
//   mul_outn, mul_fin     boothmul product and finish flag
//   Optional: define BOOTHMUL_ARB_TIMEOUT_EN to abort operations lasting TIMEOUT cycles.
module boothmul_arbiter #(
   parameter int N_REQ   = 4,
   parameter int IDX_W   = 2,
   parameter int A1_LEN  = 32,
   parameter int A2_LEN  = 32,
   parameter int TIMEOUT = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*A1_LEN-1:0]  a1_in,
   input  logic [N_REQ*A2_LEN-1:0]  a2_in,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         done,
   output logic [A1_LEN+A2_LEN-1:0] result,
   output logic                     err,
   output logic                     busy,
   output logic                     mul_arm,
   output logic [A1_LEN-1:0]        mul_a1,
   output logic [A2_LEN-1:0]        mul_a2,
   input  logic [A1_LEN+A2_LEN-1:0] mul_outn,
   input  logic                     mul_fin
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   state_t                   r_state, w_next;
   logic [IDX_W-1:0]         r_ptr, r_owner, w_off, w_win;
   logic [IDX_W:0]           w_sum;
   logic [N_REQ-1:0]         w_rot, r_grant, r_done;
   logic [A1_LEN-1:0]        r_a1, w_a1;
   logic [A2_LEN-1:0]        r_a2, w_a2;
   logic [A1_LEN+A2_LEN-1:0] r_result;
   logic                     r_arm, w_start, w_cap, w_tmo;
   // Rotate requests so bit 0 is the pointer's requester; the lowest set bit is the winner.
   always_comb begin
      w_rot = N_REQ'({req, req} >> r_ptr);
      w_off = '0;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (w_rot[k]) w_off = IDX_W'(k);
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      w_win = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ)) : IDX_W'(w_sum);
      w_a1  = '0;
      w_a2  = '0;
      for (int i = 0; i < N_REQ; i++)
         if (w_win == IDX_W'(i)) begin
            w_a1 = a1_in[i*A1_LEN +: A1_LEN];
            w_a2 = a2_in[i*A2_LEN +: A2_LEN];
         end
   end
   always_comb begin
      w_start = (r_state == S_IDLE) && |req;
      w_cap   = (r_state == S_BUSY) && (mul_fin || w_tmo);
      w_next  = w_start ? S_BUSY : w_cap ? S_DONE : (r_state == S_DONE) ? S_IDLE : r_state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_ptr    <= '0;
         r_owner  <= '0;
         r_grant  <= '0;
         r_done   <= '0;
         r_result <= '0;
         r_arm    <= 1'b0;
         r_a1     <= '0;
         r_a2     <= '0;
      end else begin
         if (w_start) begin
            r_owner <= w_win;
            r_grant <= N_REQ'(1) << w_win;
            r_a1    <= w_a1;
            r_a2    <= w_a2;
            r_arm   <= 1'b1;
         end
         if (w_cap) begin
            r_result <= w_tmo ? '0 : mul_outn;
            r_done   <= r_grant;
            r_arm    <= 1'b0;
         end
         if (r_state == S_DONE) begin
            r_done  <= '0;
            r_grant <= '0;
            r_ptr   <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
         end
      end
`ifdef BOOTHMUL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   // Counter restarts on every entry to BUSY; a late mul_fin on the last cycle still wins.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= (r_state == S_BUSY) ? r_cnt + 1'b1 : '0;
   assign w_tmo = !mul_fin && (r_cnt == CNT_W'(TIMEOUT - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                 r_err <= 1'b0;
      else if (w_cap)             r_err <= w_tmo;
      else if (r_state == S_DONE) r_err <= 1'b0;
   assign err = r_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = TIMEOUT > 0;
   assign w_tmo = 1'b0;
   assign err   = 1'b0;
`endif
   assign grant   = r_grant;
   assign done    = r_done;
   assign result  = r_result;
   assign busy    = r_state != S_IDLE;
   assign mul_arm = r_arm;
   assign mul_a1  = r_a1;
   assign mul_a2  = r_a2;
endmodule

// File: tb/tb_boothmul_arbiter.sv
// tb_boothmul_arbiter: randomized checks of boothmul_arbiter against a round-robin reference model.
module tb_boothmul_arbiter;
   localparam int W = 32;
   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [3:0]    req = '0;
   logic [127:0]  a1_in = '0, a2_in = '0;
   logic [3:0]    grant, done;
   logic [63:0]   result, mul_outn;
   logic          err, busy, mul_arm, mul_fin;
   logic [31:0]   mul_a1, mul_a2;
   int            vectors = 0, miscompares = 0, ptr_m = 0;
   logic [31:0]   op1 [4], op2 [4];
   int            stub_cnt;
   logic          stub_stall = 1'b0;

   always #5 clk = ~clk;

   boothmul_arbiter #(.N_REQ(4), .IDX_W(2), .A1_LEN(W), .A2_LEN(W), .TIMEOUT(40)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a1_in(a1_in), .a2_in(a2_in),
      .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
      .mul_arm(mul_arm), .mul_a1(mul_a1), .mul_a2(mul_a2),
      .mul_outn(mul_outn), .mul_fin(mul_fin));

   function automatic logic [63:0] mulref(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] x, y;
      x = $signed(a);
      y = $signed(b);
      return x * y;
   endfunction

   // Stand-in boothmul: finishes A2_LEN+2 cycles after arm rises; product is garbage until then.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stub_cnt <= 0;
      else        stub_cnt <= mul_arm ? stub_cnt + 1 : 0;
   assign mul_fin  = mul_arm && !stub_stall && stub_cnt >= W + 2;
   assign mul_outn = mul_fin ? mulref(mul_a1, mul_a2) : 64'hDEAD_BEEF_0BAD_F00D;

   function automatic int pick(input logic [3:0] r);
      for (int k = 0; k < 4; k++)
         if (r[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
      return -1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [31:0] x, input logic [31:0] y);
      op1[i] = x;
      op2[i] = y;
      a1_in[i*32 +: 32] = x;
      a2_in[i*32 +: 32] = y;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (grant != 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output int edges);
      edges = -1;
      for (int n = 1; n <= 200; n++) begin
         tick();
         if (done != 0) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if ({grant, done, err, busy, mul_arm} !== 11'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 0", {grant, done, err, busy, mul_arm});
      end
      vectors++;
      if (result !== 64'b0) begin
         miscompares++;
         $display("FAIL reset_result: got %h expected 0", result);
      end
      vectors++;
      if ({mul_a1, mul_a2} !== 64'b0) begin
         miscompares++;
         $display("FAIL reset_operands: got %h expected 0", {mul_a1, mul_a2});
      end
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      tick();
   endtask

   task automatic test_contention;
      int w, e;
      bit ok;
      logic [63:0] p;
      for (int i = 0; i < 4; i++) set_ops(i, $urandom, $urandom);
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         w = pick(req);
         wait_grant(ok);
         vectors++;
         if (!ok || grant !== 4'(1 << w)) begin
            miscompares++;
            $display("FAIL contention_grant[%0d]: got %b expected %b", n, grant, 4'(1 << w));
         end
         p = mulref(op1[w], op2[w]);
         set_ops(w, $urandom, $urandom);
         wait_done(e);
         vectors++;
         if (e != 35 || done !== 4'(1 << w) || result !== p) begin
            miscompares++;
            $display("FAIL contention_done[%0d]: edges=%0d done=%b result=%h, expected edges=35 done=%b result=%h",
                     n, e, done, result, 4'(1 << w), p);
         end
         ptr_m = (w + 1) % 4;
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_single;
      int e;
      bit ok;
      logic [63:0] exp_p;
      exp_p = 64'(-42);
      set_ops(0, 32'(-7), 32'd6);
      req = 4'b0001;
      wait_grant(ok);
      vectors++;
      if (!ok || grant !== 4'b0001 || mul_arm !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_grant: grant=%b arm=%b busy=%b expected 0001 1 1", grant, mul_arm, busy);
      end
      req = '0;
      wait_done(e);
      vectors++;
      if (e != 35 || done !== 4'b0001 || result !== exp_p || err !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: edges=%0d done=%b result=%h err=%b, expected 35 0001 %h 0", e, done, result, err, exp_p);
      end
      tick();
      vectors++;
      if (done !== 4'b0 || grant !== 4'b0 || busy !== 1'b0 || mul_arm !== 1'b0 || result !== exp_p) begin
         miscompares++;
         $display("FAIL single_after: done=%b grant=%b busy=%b arm=%b result=%h expected all idle, result held",
                  done, grant, busy, mul_arm, result);
      end
      ptr_m = 1;
   endtask

   task automatic test_extremes;
      int e;
      bit ok;
      logic [31:0] xa [2], xb [2];
      logic [63:0] xp [2];
      xa[0] = 32'h8000_0000; xb[0] = 32'h8000_0000; xp[0] = 64'h4000_0000_0000_0000;
      xa[1] = 32'hFFFF_FFFF; xb[1] = 32'd1;         xp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int n = 0; n < 2; n++) begin
         set_ops(3, xa[n], xb[n]);
         req = 4'b1000;
         wait_grant(ok);
         req = '0;
         wait_done(e);
         vectors++;
         if (!ok || done !== 4'b1000 || result !== xp[n]) begin
            miscompares++;
            $display("FAIL extremes[%0d]: done=%b result=%h expected 1000 %h", n, done, result, xp[n]);
         end
         ptr_m = 0;
         tick();
      end
   endtask

   task automatic test_abandon;
      int e;
      bit ok;
      logic [31:0] orig;
      logic [63:0] p;
      set_ops(2, $urandom, $urandom);
      orig = op1[2];
      p = mulref(op1[2], op2[2]);
      req = 4'b0100;
      wait_grant(ok);
      vectors++;
      if (!ok || grant !== 4'b0100) begin
         miscompares++;
         $display("FAIL abandon_grant: got %b expected 0100", grant);
      end
      tick();
      tick();
      req = '0;
      a1_in[64 +: 32] = ~orig;
      a2_in[64 +: 32] = ~op2[2];
      tick();
      vectors++;
      if (mul_a1 !== orig || mul_arm !== 1'b1) begin
         miscompares++;
         $display("FAIL abandon_freeze: mul_a1=%h arm=%b expected %h 1", mul_a1, mul_arm, orig);
      end
      wait_done(e);
      vectors++;
      if (e != 32 || done !== 4'b0100 || result !== p) begin
         miscompares++;
         $display("FAIL abandon_done: edges=%0d done=%b result=%h expected 32 0100 %h", e, done, result, p);
      end
      ptr_m = 3;
      tick();
   endtask

   task automatic test_random;
      int w, e;
      bit ok;
      logic [3:0] m;
      logic [63:0] p;
      for (int n = 0; n < 16; n++) begin
         m = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) set_ops(i, $urandom, $urandom);
         req = m;
         w = pick(m);
         wait_grant(ok);
         vectors++;
         if (!ok || grant !== 4'(1 << w)) begin
            miscompares++;
            $display("FAIL random_grant[%0d]: req=%b got %b expected %b", n, m, grant, 4'(1 << w));
         end
         p = mulref(op1[w], op2[w]);
         req = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) set_ops(i, $urandom, $urandom);
         wait_done(e);
         vectors++;
         if (e != 35 || done !== 4'(1 << w) || result !== p || err !== 1'b0) begin
            miscompares++;
            $display("FAIL random_done[%0d]: edges=%0d done=%b result=%h err=%b, expected 35 %b %h 0",
                     n, e, done, result, err, 4'(1 << w), p);
         end
         ptr_m = (w + 1) % 4;
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_async_reset;
      int w, e;
      bit ok;
      logic [63:0] p;
      set_ops(0, $urandom, $urandom);
      req = 4'b0001;
      wait_grant(ok);
      for (int n = 0; n < 5; n++) tick();
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if ({grant, done, err, busy, mul_arm} !== 11'b0 || result !== 64'b0 || {mul_a1, mul_a2} !== 64'b0) begin
         miscompares++;
         $display("FAIL async_reset: ctrl=%b result=%h ops=%h expected all 0",
                  {grant, done, err, busy, mul_arm}, result, {mul_a1, mul_a2});
      end
      req = 4'b1010;
      set_ops(1, $urandom, $urandom);
      set_ops(3, $urandom, $urandom);
      #2 rst_n = 1'b1;
      ptr_m = 0;
      w = pick(req);
      wait_grant(ok);
      vectors++;
      if (!ok || grant !== 4'b0010) begin
         miscompares++;
         $display("FAIL async_regrant: got %b expected 0010", grant);
      end
      p = mulref(op1[w], op2[w]);
      req = '0;
      wait_done(e);
      vectors++;
      if (e != 35 || done !== 4'b0010 || result !== p) begin
         miscompares++;
         $display("FAIL async_done: edges=%0d done=%b result=%h expected 35 0010 %h", e, done, result, p);
      end
      ptr_m = (w + 1) % 4;
      tick();
   endtask

`ifdef BOOTHMUL_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int e;
      bit ok;
      logic [63:0] p;
      stub_stall = 1'b1;
      set_ops(0, $urandom, $urandom);
      req = 4'b0001;
      wait_grant(ok);
      req = '0;
      wait_done(e);
      vectors++;
      if (e != 40 || done !== 4'b0001 || err !== 1'b1 || result !== 64'b0) begin
         miscompares++;
         $display("FAIL timeout_done: edges=%0d done=%b err=%b result=%h expected 40 0001 1 0", e, done, err, result);
      end
      tick();
      vectors++;
      if (err !== 1'b0 || done !== 4'b0 || grant !== 4'b0) begin
         miscompares++;
         $display("FAIL timeout_clear: err=%b done=%b grant=%b expected 0", err, done, grant);
      end
      ptr_m = 1;
      stub_stall = 1'b0;
      set_ops(0, $urandom, $urandom);
      p = mulref(op1[0], op2[0]);
      req = 4'b0001;
      wait_grant(ok);
      req = '0;
      wait_done(e);
      vectors++;
      if (e != 35 || done !== 4'b0001 || err !== 1'b0 || result !== p) begin
         miscompares++;
         $display("FAIL timeout_next: edges=%0d done=%b err=%b result=%h expected 35 0001 0 %h", e, done, err, result, p);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_extremes();
      test_abandon();
      test_random();
      test_async_reset();
`ifdef BOOTHMUL_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
